// File: rtl/mp3_pkg.sv
// Shared definitions for the MP3 granule decode path: granule geometry,
// the signed frequency-line sample type and the pair sequencer state encoding.
package mp3_pkg;

   localparam int SAMPLES_PER_GRANULE = 576;
   localparam int SAMPLE_ADDR_W       = 10;
   localparam int BIG_VALUES_MAX      = SAMPLES_PER_GRANULE / 2;

   typedef logic signed [15:0] sample_t;

   typedef enum logic [2:0] {
      IDLE,
      COLLECT,
      WRITE_Y,
      ZFILL,
      DONE
   } hps_state_t;

endpackage

// File: rtl/hd_pair_sequencer_if.sv
// Bundle between the Huffman pair decoder / granule controller and the pair
// sequencer, plus the sample RAM write port and status it drives back.
interface hd_pair_sequencer_if
   import mp3_pkg::*;
#(
   parameter int ADDR_W = SAMPLE_ADDR_W
) ();

   // Handshake: there is no ready. pair_valid is a single-cycle pulse and the
   // pair (x_val, y_val) is valid only in that cycle; the sequencer must take
   // it then or flag it as dropped. start is likewise a one-cycle pulse.
   logic                 start;
   logic [8:0]           big_values;
   logic                 pair_valid;
   sample_t              x_val;
   sample_t              y_val;

   logic                 wr_en;
   logic [ADDR_W-1:0]    wr_addr;
   sample_t              wr_data;
   logic                 busy;
   logic                 done;
   logic                 err_overflow;
   logic                 err_range;
   hps_state_t           state;

   modport master (
      output start, big_values, pair_valid, x_val, y_val,
      input  wr_en, wr_addr, wr_data, busy, done, err_overflow, err_range, state
   );

   modport slave (
      input  start, big_values, pair_valid, x_val, y_val,
      output wr_en, wr_addr, wr_data, busy, done, err_overflow, err_range, state
   );

endinterface

// File: rtl/hd_pair_sequencer.sv
// Writes decoded Huffman (x,y) pairs as consecutive samples into the granule
// sample RAM, then zero-fills the remainder of the granule and pulses done.
module hd_pair_sequencer
   import mp3_pkg::*;
#(
   parameter int SAMPLES = SAMPLES_PER_GRANULE,
   parameter int ADDR_W  = SAMPLE_ADDR_W,
   parameter int BV_MAX  = BIG_VALUES_MAX
) (
   input  logic                 clk,
   input  logic                 rst,
   hd_pair_sequencer_if.slave   bus
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SAMPLES - 1);
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_TWO  = ADDR_W'(2);
   localparam logic [8:0]        BV_LIMIT  = 9'(BV_MAX);

   hps_state_t         state_q, state_d;
   logic [8:0]         bv_q, bv_d;
   logic [8:0]         cnt_q, cnt_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   sample_t            y_hold_q, y_hold_d;
   logic               wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
   sample_t            wr_data_q, wr_data_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               err_ov_q, err_ov_d;
   logic               err_rng_q, err_rng_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         bv_q      <= '0;
         cnt_q     <= '0;
         addr_q    <= '0;
         y_hold_q  <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_ov_q  <= 1'b0;
         err_rng_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         bv_q      <= bv_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         y_hold_q  <= y_hold_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_ov_q  <= err_ov_d;
         err_rng_q <= err_rng_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      bv_d      = bv_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      y_hold_d  = y_hold_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      err_ov_d  = err_ov_q;
      err_rng_d = err_rng_q;

      case (state_q)
         IDLE: begin
            // A start coinciding with the done pulse belongs to the old granule.
            if (bus.start && !done_q) begin
               if (bus.big_values > BV_LIMIT) begin
                  bv_d      = BV_LIMIT;
                  err_rng_d = 1'b1;
               end else begin
                  bv_d = bus.big_values;
               end
               cnt_d   = '0;
               addr_d  = '0;
               busy_d  = 1'b1;
               state_d = (bus.big_values == 9'd0) ? ZFILL : COLLECT;
            end
         end

         COLLECT: begin
            if (bus.pair_valid) begin
               wr_en_d   = 1'b1;
               wr_addr_d = addr_q;
               wr_data_d = bus.x_val;
               y_hold_d  = bus.y_val;
               state_d   = WRITE_Y;
            end
         end

         WRITE_Y: begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q + ADDR_ONE;
            wr_data_d = y_hold_q;
            addr_d    = addr_q + ADDR_TWO;
            cnt_d     = cnt_q + 9'd1;
            if (bus.pair_valid) begin
               err_ov_d = 1'b1;
            end
            if (cnt_q + 9'd1 == bv_q) begin
               state_d = (bv_q == BV_LIMIT) ? DONE : ZFILL;
            end else begin
               state_d = COLLECT;
            end
         end

         ZFILL: begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = '0;
            if (bus.pair_valid) begin
               err_ov_d = 1'b1;
            end
            if (addr_q == LAST_ADDR) begin
               state_d = DONE;
            end else begin
               addr_d = addr_q + ADDR_ONE;
            end
         end

         DONE: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   assign bus.wr_en        = wr_en_q;
   assign bus.wr_addr      = wr_addr_q;
   assign bus.wr_data      = wr_data_q;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.err_overflow = err_ov_q;
   assign bus.err_range    = err_rng_q;
   assign bus.state        = state_q;

endmodule
